// File: rtl/downcounter_reload_if.sv
// Control/status bundle for the loadable down-counter: the master side drives
// load data and mode controls, the slave side returns the count and status flags.
interface downcounter_reload_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output data, load, en, auto_reload,
    input  count, tc, busy, done
  );

  modport slave (
    input  data, load, en, auto_reload,
    output count, tc, busy, done
  );
endinterface

// File: rtl/downcounter_reload.sv
// Loadable down-counter/timer producing a one-cycle terminal tick, then
// either stopping (one-shot, sticky done) or reloading (periodic).
module downcounter_reload #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  downcounter_reload_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state evaluation: load beats the terminal event, which beats decrement/hold.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load) begin
      count_d  = bus.data;
      reload_d = bus.data;
      if (bus.data != {WIDTH{1'b0}}) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (bus.en) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (bus.auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = {WIDTH{1'b0}};
                state_d = ST_DONE;
              end
            end else if (count_q != {WIDTH{1'b0}}) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Zero in RUN is unreachable; hold rather than wrap.
              count_d = count_q;
            end
          end else begin
            count_d = count_q;
          end
        end
        ST_DONE: begin
          count_d = {WIDTH{1'b0}};
        end
        default: begin
          state_d = ST_IDLE;
          count_d = {WIDTH{1'b0}};
        end
      endcase
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, counter, reload value and status flags, all registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= {WIDTH{1'b0}};
      reload_q <= {WIDTH{1'b0}};
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_downcounter_reload.sv
// Directed bench for downcounter_reload: hand-computed vectors checked with
// immediate assertions after each rising edge.
module tb_downcounter_reload;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   ticks_seen;

  downcounter_reload_if #(.WIDTH(8)) bus ();

  downcounter_reload #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] c, input logic t,
                         input logic b, input logic d);
    chk({tag, ".count"}, {24'd0, bus.count}, {24'd0, c});
    chk({tag, ".tc"},    {31'd0, bus.tc},    {31'd0, t});
    chk({tag, ".busy"},  {31'd0, bus.busy},  {31'd0, b});
    chk({tag, ".done"},  {31'd0, bus.done},  {31'd0, d});
  endtask

  initial begin
    logic       en_pat [6];
    logic [7:0] gap_exp[6];
    en_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    gap_exp = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h01, 8'h00};
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    bus.data = 8'h00;
    bus.load = 1'b0;
    bus.en = 1'b0;
    bus.auto_reload = 1'b0;
    tick();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // One-shot from 5
    bus.load = 1'b1; bus.data = 8'h05; bus.auto_reload = 1'b0;
    tick();
    chk_all("os_load", 8'h05, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b0; bus.en = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk_all("os_dec", 8'(i), 1'b0, 1'b1, 1'b0);
    end
    tick();
    chk_all("os_term", 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("os_hold", 8'h00, 1'b0, 1'b0, 1'b1);
    end

    // Periodic with period 3
    bus.load = 1'b1; bus.data = 8'h03; bus.auto_reload = 1'b1;
    tick();
    chk_all("per_load", 8'h03, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.tc === 1'b1) ticks_seen++;
      if ((i % 3) == 2) chk_all("per_wrap", 8'h03, 1'b1, 1'b1, 1'b0);
      else              chk_all("per_dec", 8'(2 - (i % 3)), 1'b0, 1'b1, 1'b0);
    end
    chk("per_ticks", 32'(ticks_seen), 32'd4);

    // Enable gaps
    bus.load = 1'b1; bus.data = 8'h04; bus.auto_reload = 1'b0; bus.en = 1'b0;
    tick();
    chk_all("gap_load", 8'h04, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.en = en_pat[i];
      tick();
      if (i == 5) chk_all("gap_term", gap_exp[i], 1'b1, 1'b0, 1'b1);
      else        chk_all("gap_step", gap_exp[i], 1'b0, 1'b1, 1'b0);
    end

    // Load colliding with a terminal event, then a zero load
    bus.load = 1'b1; bus.data = 8'h02; bus.auto_reload = 1'b1; bus.en = 1'b1;
    tick();
    chk_all("col_load", 8'h02, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b0;
    tick();
    chk_all("col_one", 8'h01, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b1; bus.data = 8'h07;
    tick();
    chk_all("col_win", 8'h07, 1'b0, 1'b1, 1'b0);
    bus.data = 8'h00;
    tick();
    chk_all("zero_load", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("zero_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-run
    bus.load = 1'b1; bus.data = 8'hA0; bus.auto_reload = 1'b0; bus.en = 1'b1;
    tick();
    chk_all("ar_load", 8'hA0, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all("ar_dec", 8'(8'hA0 - i), 1'b0, 1'b1, 1'b0);
    end
    #2 reset = 1'b0;
    #1;
    chk_all("ar_async", 8'h00, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("ar_after", 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Maximum load value, one-shot
    bus.load = 1'b1; bus.data = 8'hFF; bus.auto_reload = 1'b0; bus.en = 1'b1;
    tick();
    chk_all("max_load", 8'hFF, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (bus.tc === 1'b1) ticks_seen++;
    end
    chk("max_early_tc", 32'(ticks_seen), 32'd0);
    chk_all("max_one", 8'h01, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("max_term", 8'h00, 1'b1, 1'b0, 1'b1);

    // Mode switch from periodic to one-shot mid-period
    bus.load = 1'b1; bus.data = 8'h03; bus.auto_reload = 1'b1; bus.en = 1'b1;
    tick();
    chk_all("ms_load", 8'h03, 1'b0, 1'b1, 1'b0);
    bus.load = 1'b0;
    tick();
    chk_all("ms_dec2", 8'h02, 1'b0, 1'b1, 1'b0);
    bus.auto_reload = 1'b0;
    tick();
    chk_all("ms_dec1", 8'h01, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("ms_term", 8'h00, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/downcounter_reload.md
Name: downcounter_reload

Overview:
Loadable down-counter/timer, the counting-down counterpart of the team's 8-bit loadable up-counter. It loads a start value and decrements on enabled clocks. When it reaches the terminal count it emits a one-cycle tick. It then either stops (one-shot) or reloads automatically (periodic). It serves as the programmable interval/timeout source next to the up-counter in the same datapath.

Parameters:
WIDTH, 8, counter and load-data width in bits.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset; the counter is held in reset while reset=0.
data  input  WIDTH  start/reload value; sampled only when load=1.
load  input  1  synchronous load strobe; highest priority after reset.
en  input  1  count enable; decrement only in RUN with en=1.
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at each terminal event.
count  output  WIDTH  current counter value (registered).
tc  output  1  terminal-count tick; registered, high for exactly one cycle per terminal event.
busy  output  1  high while in RUN.
done  output  1  sticky one-shot completion flag; high in DONE.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - count=0, reload register=0, tc=0, busy=0, done=0, state=IDLE.
  - Release is synchronous in effect: the first rising edge with reset=1 evaluates normally.
- Internal reload register (WIDTH bits) captures data on every load.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE); both registered.
- Priority at each rising edge: reset > load > terminal/decrement > hold.
- load=1 (any state):
  - count<=data, reload register<=data, tc<=0.
  - Next state is RUN if data!=0, else IDLE (count=0, no tc).
  - load=1 coinciding with a terminal event: load wins, tc stays 0.
- IDLE: count holds; en and auto_reload ignored; exits only via load.
- RUN, en=0: count holds, tc<=0, stay RUN.
- RUN, en=1, count>1: count<=count-1, tc<=0.
- RUN, en=1, count==1 (terminal event), tc<=1, then:
  - auto_reload=1: count<=reload register, stay RUN. Period is exactly N enabled cycles for load value N.
  - auto_reload=0: count<=0, state<=DONE.
- DONE: count holds 0, tc<=0, en ignored; exits only via load.
- tc deasserts on the edge after it asserts, so it is never high two consecutive cycles. Exception: periodic mode with N=1 gives tc continuously high while en=1, one tick per cycle.
- Count never wraps below 0. Value 0 is reached only via one-shot terminal or a load of 0.
- auto_reload may change at any time; only its value at the terminal edge matters.
- Reset asserted mid-RUN: immediate return to reset values; the pending tc is lost.
- WIDTH arithmetic: plain unsigned decrement; the maximum load value 2^WIDTH-1 is legal and gives that many enabled cycles to terminal.

Test Plan:
- One-shot: reset pulse, then load=1 data=8'h05 auto_reload=0, then en=1 -> count 05,04,03,02,01,00 on successive edges. tc=1 only during the cycle count=00. done=1 and busy=0 from that edge; count stays 00 for 10 further enabled cycles.
- Periodic: load data=8'h03 auto_reload=1, en=1 for 12 cycles -> count 03,02,01,03,02,01,... with tc high every 3rd cycle (4 ticks). busy stays 1, done stays 0.
- Enable gaps: load 8'h04, en pattern 1,0,0,1,1,1 -> count 04,03,03,03,02,01,00. tc asserts only on the final edge; count holds while en=0.
- Load collision and zero load:
  - Periodic 8'h02 running, load=1 data=8'h07 on the edge where count==1 -> count=07, tc=0, stays RUN.
  - Load data=8'h00 -> count=00, IDLE, busy=0, done=0, no tc for 5 enabled cycles.
- Async reset mid-operation: load 8'hA0, count to 8'h9C, drive reset=0 between clock edges -> count=00, tc=0, busy=0, done=0 immediately without a clk edge. With reset=1 and en=1, count stays 00 until the next load.
- Max value and mode switch:
  - Load 8'hFF one-shot with en=1 -> tc after exactly 255 enabled cycles.
  - Separately, switch auto_reload 1->0 mid-period on an 8'h03 load -> the next terminal ends in DONE, not a reload.
